baud_generator_os: RTL
======================

// Module: baud_generator_os
// PURPOSE
//   Parametrised UART baud/oversample tick generator with independent TX and RX timing channels.
//   Replaces the fixed 16-bit single-divisor generator.
//   Adds staged divisor writes with atomic commit, per-channel enables, readback, and an oversample tick per channel.
//   Sits between the register interface (SPART/UART bus decode) and the TX/RX shift engines.
// PARAMETERS
//   DIV_W       16   divisor width; requirement BUS_W < DIV_W <= 2*BUS_W
//   BUS_W       8    register write/read data width
//   OVERSAMPLE  16   sample ticks per bit; requirement: even, >= 2
//   DEFAULT_DIV 326  divisor after reset (9600 baud at 50 MHz with OVERSAMPLE=16)
// PORTS
//   clk        in   1        system clock
//   rst_n      in   1        synchronous active-low reset
//   wr_en      in   1        register write strobe, one cycle
//   wr_addr    in   2        0=DIV_LO stage, 1=DIV_HI stage, 2=COMMIT, 3=CTRL
//   wr_data    in   BUS_W    write data
//   rd_data    out  BUS_W    combinational readback of register at wr_addr
//   tx_start   in   1        restart TX bit timing
//   rx_start   in   1        restart RX timing at half-bit phase (start-bit edge)
//   tx_sample  out  1        TX oversample tick, 1-cycle pulse
//   tx_baud    out  1        TX bit tick, 1-cycle pulse
//   rx_sample  out  1        RX oversample tick, 1-cycle pulse
//   rx_baud    out  1        RX bit-centre tick, 1-cycle pulse
// BEHAVIOUR
//   Reset (rst_n low at rising edge):
//     div_act = div_stg = DEFAULT_DIV; ctrl = 2'b11.
//     All outputs 0; prescalers = DEFAULT_DIV; tx_os = OVERSAMPLE-1; rx_os = OVERSAMPLE/2-1.
//     Reset mid-operation aborts all counts; there is no pending state.
//   Registers:
//     DIV_LO write -> div_stg[BUS_W-1:0].
//     DIV_HI write -> div_stg[DIV_W-1:BUS_W] from wr_data[DIV_W-BUS_W-1:0].
//     COMMIT write -> div_act <= div_stg (wr_data ignored).
//     CTRL write -> bit0 tx_en, bit1 rx_en.
//     Staging writes never affect timing.
//     Writes do not stall counters (unlike the previous generation).
//   rd_data:
//     addr0/1 = div_act low/high slice, zero-extended.
//     addr2 = div_stg low slice.
//     addr3 = {0, rx_en, tx_en}.
//   Per channel (TX shown; RX identical, using rx_* signals):
//     Channel disabled: pre <= div_act, os <= reload value, outputs 0, starts ignored.
//     Start asserted: pre <= div_act, os <= reload, outputs 0 that cycle.
//       Start has priority over a coincident tick.
//     Otherwise, if pre==0: pre <= div_act and sample <= 1.
//       If os==0: os <= OVERSAMPLE-1 and baud <= 1.
//       Else: os <= os-1.
//     Otherwise: pre <= pre-1; sample, baud <= 0.
//     Reload value: TX os = OVERSAMPLE-1; RX os on start = OVERSAMPLE/2-1.
//       After first rx_baud, RX os reloads with OVERSAMPLE-1.
//   Timing (D = div_act):
//     sample period = D+1 clocks; bit period = OVERSAMPLE*(D+1).
//     First tx_baud is high the cycle after edge OVERSAMPLE*(D+1), counting the start-sampling edge as 0.
//     First rx_baud follows edge (OVERSAMPLE/2)*(D+1), then every OVERSAMPLE*(D+1).
//     baud pulses always coincide with a sample pulse.
//   D=0 is legal: sample ticks every clock.
//   COMMIT mid-count: current prescaler count completes; new D applies from the next reload.
//   All arithmetic is unsigned DIV_W bits; counters never wrap below 0 (reloaded at 0).
// TESTING
//   Reset, D=326, tx_start at t0 -> tx_sample every 327 clk; tx_baud exactly once per 5232 clk; outputs 0 during reset.
//   Write LO=3, HI=0, no COMMIT -> timing unchanged and rd_data(addr0)=0x46; after COMMIT with tx_start -> tx_baud after 64 edges, then every 64.
//   D=3, rx_start -> first rx_baud after 32 edges, next after 96; rx_start retriggered mid-bit restarts half-bit phase.
//   tx_start coincident with pre==0, os==0 -> no tx_baud that cycle; counts restart from D.
//   COMMIT D=7 while pre=2 (old D=3) -> two more decrements, next sample period 8 clk; CTRL=0 -> all outputs held 0, starts ignored.
//   D=0, OVERSAMPLE=2 -> tx_sample high every clk, tx_baud every 2nd clk; rst_n low mid-stream -> outputs 0 the next cycle.

Source files
------------

// File: rtl/baud_generator_os_if.sv
// baud_generator_os_if: register write/readback bus between UART decode and the baud generator
interface baud_generator_os_if #(parameter int BUS_W = 8);
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [BUS_W-1:0] wr_data;
  logic [BUS_W-1:0] rd_data;
  modport master (output wr_en, wr_addr, wr_data, input rd_data);
  modport slave (input wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/baud_generator_os.sv
// baud_generator_os: staged-divisor UART oversample/bit tick generator with independent TX and RX channels
module baud_generator_os #(
  parameter int DIV_W       = 16,
  parameter int BUS_W       = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int DEFAULT_DIV = 326
) (
  input  logic                 clk,
  input  logic                 rst_n,
  baud_generator_os_if.slave   bus,
  input  logic                 tx_start,
  input  logic                 rx_start,
  output logic                 tx_sample,
  output logic                 tx_baud,
  output logic                 rx_sample,
  output logic                 rx_baud
);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_TOP = OSW'(OVERSAMPLE - 1);
  localparam logic [OSW-1:0] OS_HALF = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
  logic [DIV_W-1:0] div_act, div_stg;
  logic [1:0] ctrl, st, smp, bd;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_act <= DIV_RST;
      div_stg <= DIV_RST;
      ctrl    <= 2'b11;
    end else if (bus.wr_en) begin
      if (bus.wr_addr == 2'd0) div_stg[BUS_W-1:0] <= bus.wr_data;
      if (bus.wr_addr == 2'd1) div_stg[DIV_W-1:BUS_W] <= bus.wr_data[DIV_W-BUS_W-1:0];
      if (bus.wr_addr == 2'd2) div_act <= div_stg;
      if (bus.wr_addr == 2'd3) ctrl <= bus.wr_data[1:0];
    end
  end
  always_comb
    bus.rd_data = bus.wr_addr == 2'd0 ? div_act[BUS_W-1:0] :
                  bus.wr_addr == 2'd1 ? BUS_W'(div_act >> BUS_W) :
                  bus.wr_addr == 2'd2 ? div_stg[BUS_W-1:0] : BUS_W'(ctrl);
  assign st = {rx_start, tx_start};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    // RX restarts at half-bit phase so its bit tick lands mid-bit
    localparam logic [OSW-1:0] RLD = (c == 1) ? OS_HALF : OS_TOP;
    logic [DIV_W-1:0] pre;
    logic [OSW-1:0]   os;
    logic             s, b;
    always_ff @(posedge clk) begin
      if (!rst_n || !ctrl[c] || st[c]) begin
        pre <= rst_n ? div_act : DIV_RST;
        os  <= RLD;
        s   <= 1'b0;
        b   <= 1'b0;
      end else if (pre == '0) begin
        pre <= div_act;
        os  <= (os == '0) ? OS_TOP : os - 1'b1;
        s   <= 1'b1;
        b   <= (os == '0);
      end else begin
        pre <= pre - 1'b1;
        s   <= 1'b0;
        b   <= 1'b0;
      end
    end
    assign smp[c] = s;
    assign bd[c] = b;
  end
  assign tx_sample = smp[0];
  assign tx_baud = bd[0];
  assign rx_sample = smp[1];
  assign rx_baud = bd[1];
endmodule
